// File: rtl/flash_reader_pkg.sv
// Shared widths, default sizing and the FSM state type for the flash read engine.
package flash_reader_pkg;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 64;
    localparam int BEAT_W         = 5;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_MAX_BEATS  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ERR
    } state_t;
endpackage

// File: rtl/flash_reader_fifo.sv
// Response buffer: synchronous FIFO of {data, last} with an occupancy count.
module flash_reader_fifo
    import flash_reader_pkg::*;
#(
    parameter int  DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_empty,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_count
);
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic              r_mem_last [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (i_push) begin
            r_mem_data[r_wr_ptr] <= i_data;
            r_mem_last[r_wr_ptr] <= i_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem_data[r_rd_ptr];
    assign o_last  = r_mem_last[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
endmodule

// File: rtl/flash_reader.sv
// Burst reader: accepts a request, streams 64-bit beats out of flash through a
// credit-limited response FIFO.
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | strobing flash reads while FIFO credit allows
//   DRAIN | all reads issued, waiting for the last beat to be taken
//   ERR   | presenting the single error beat of a rejected request
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BEAT_W-1:0] req_beats,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    output logic              flash_r_en,
    output logic [ADDR_W-1:0] flash_r_addr,
    input  logic [DATA_W-1:0] flash_r_data
);
    localparam int              CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam logic [BEAT_W:0] LP_MAX_BEATS = (BEAT_W + 1)'(MAX_BEATS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [BEAT_W-1:0] r_beats;
    logic [BEAT_W-1:0] r_issued;
    logic [ADDR_W-1:0] r_flash_addr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_req_bad;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_credit_ok;
    logic [CNT_W:0]    w_occ;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_last;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_req_bad = (req_addr[2:0] != 3'b000) || (req_beats == '0) ||
                       ({1'b0, req_beats} > LP_MAX_BEATS);

    // A read still in flight already owns a FIFO slot.
    assign w_occ        = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit_ok  = (w_occ < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_last_issue = (r_issued == r_beats - 1'b1);
    assign w_next_addr  = (r_issued == '0) ? r_base : r_flash_addr + ADDR_W'(8);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_req_bad ? ERR : ISSUE;
            end
            ISSUE: begin
                w_issue = w_credit_ok;
                if (w_credit_ok && w_last_issue) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_pop && w_fifo_last) w_state_nxt = IDLE;
            end
            ERR: begin
                if (resp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_base          <= '0;
            r_beats         <= '0;
            r_issued        <= '0;
            r_flash_addr    <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_issue;
            if (req_valid && req_ready && !w_req_bad) begin
                r_base   <= req_addr;
                r_beats  <= req_beats;
                r_issued <= '0;
            end
            if (w_issue) begin
                r_issued     <= r_issued + 1'b1;
                r_flash_addr <= w_next_addr;
            end
        end
    end

    assign w_push = r_inflight && !w_fifo_full;
    assign w_pop  = !w_fifo_empty && resp_ready;

    flash_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (flash_r_data),
        .i_last  (r_inflight_last),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_last  (w_fifo_last),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    assign flash_r_en   = w_issue;
    assign flash_r_addr = w_issue ? w_next_addr : r_flash_addr;
    assign resp_err     = (r_state == ERR);
    assign resp_valid   = resp_err || !w_fifo_empty;
    assign resp_last    = resp_err || (!w_fifo_empty && w_fifo_last);
    assign resp_data    = w_fifo_empty ? '0 : w_fifo_data;
endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader with a behavioural flash image and response monitor.
module tb_flash_reader;
    import flash_reader_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [4:0]  req_beats = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_data;
    logic        resp_last;
    logic        resp_err;
    logic        flash_r_en;
    logic [31:0] flash_r_addr;
    logic [63:0] flash_r_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_en  = -1;
    int first_vld = -1;
    int max_occ   = 0;

    logic [63:0] q_data [$];
    logic        q_last [$];
    logic        q_err  [$];
    int          q_hs   [$];
    logic [31:0] q_raddr[$];

    logic        p_hold = 1'b0;
    logic [63:0] p_data;
    logic        p_last;
    logic        p_err;

    flash_reader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_beats    (req_beats),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_last    (resp_last),
        .resp_err     (resp_err),
        .flash_r_en   (flash_r_en),
        .flash_r_addr (flash_r_addr),
        .flash_r_data (flash_r_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Flash image: address 0 holds a fixed word, every other address a pattern of itself.
    function automatic logic [63:0] img(input logic [31:0] a);
        if (a == 32'h0) return 64'h01f2_9293_0010_029b;
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    always @(posedge clock) if (flash_r_en) flash_r_data <= img(flash_r_addr);

    always @(negedge clock) begin
        if (reset_n) begin
            if (resp_valid && resp_ready) begin
                q_data.push_back(resp_data);
                q_last.push_back(resp_last);
                q_err.push_back(resp_err);
                q_hs.push_back(cyc);
            end
            if (flash_r_en) q_raddr.push_back(flash_r_addr);
            if (flash_r_en && first_en < 0) first_en = cyc;
            if (resp_valid && first_vld < 0) first_vld = cyc;
            if (int'(dut.w_fifo_count) > max_occ) max_occ = int'(dut.w_fifo_count);
            n_tests++;
            assert (!(dut.r_inflight && dut.w_fifo_full)) else begin
                n_fail++;
                $error("FAIL push_when_full: count=%0d, required below %0d", dut.w_fifo_count, 4);
            end
            if (p_hold) begin
                n_tests++;
                assert (resp_valid && resp_data === p_data && resp_last === p_last && resp_err === p_err) else begin
                    n_fail++;
                    $error("FAIL resp_hold: observed v=%0b d=%h l=%0b e=%0b, expected v=1 d=%h l=%0b e=%0b",
                           resp_valid, resp_data, resp_last, resp_err, p_data, p_last, p_err);
                end
            end
            p_hold = resp_valid && !resp_ready;
            p_data = resp_data;
            p_last = resp_last;
            p_err  = resp_err;
        end else begin
            p_hold = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed timeout, expected completion", name);
    endtask

    task automatic clr();
        q_data.delete();
        q_last.delete();
        q_err.delete();
        q_hs.delete();
        q_raddr.delete();
        first_en  = -1;
        first_vld = -1;
        max_occ   = 0;
    endtask

    task automatic send_req(input logic [31:0] a, input logic [4:0] b, output int acc);
        req_valid = 1'b1;
        req_addr  = a;
        req_beats = b;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (req_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (acc < 0) fail_timeout("req_accept");
    endtask

    task automatic wait_beats(input int n, input bit tgl);
        for (int k = 0; k < 400 && q_data.size() < n; k++) begin
            @(posedge clock);
            #1;
            if (tgl) resp_ready = ~resp_ready;
        end
        if (q_data.size() < n) fail_timeout("beat_wait");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready),    64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid),   64'd0);
        chk({tag, "_resp_data"},  resp_data,         64'd0);
        chk({tag, "_resp_last"},  64'(resp_last),    64'd0);
        chk({tag, "_resp_err"},   64'(resp_err),     64'd0);
        chk({tag, "_flash_en"},   64'(flash_r_en),   64'd0);
        chk({tag, "_flash_addr"}, 64'(flash_r_addr), 64'd0);
    endtask

    initial begin
        int acc_a;
        int acc_b;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk_reset_vals("rst");

        // Two beats from address 0, latency check
        @(posedge clock);
        #1;
        clr();
        resp_ready = 1'b1;
        send_req(32'h0, 5'd2, acc_a);
        wait_beats(2, 1'b0);
        chk("t1_data0", q_data[0], 64'h01f2_9293_0010_029b);
        chk("t1_last0", 64'(q_last[0]), 64'd0);
        chk("t1_data1", q_data[1], 64'hA5A5_0008_FFFF_FFF7);
        chk("t1_last1", 64'(q_last[1]), 64'd1);
        chk("t1_err",   64'({q_err[0], q_err[1]}), 64'd0);
        chk("t1_en_lat",  64'(first_en - acc_a),  64'd1);
        chk("t1_vld_lat", 64'(first_vld - acc_a), 64'd3);
        chk("t1_nreads", 64'(q_raddr.size()), 64'd2);

        // 16 beats with resp_ready toggling every cycle
        repeat (3) @(posedge clock);
        #1;
        clr();
        send_req(32'h100, 5'd16, acc_a);
        wait_beats(16, 1'b1);
        resp_ready = 1'b1;
        chk("t2_nreads", 64'(q_raddr.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_raddr", 64'(q_raddr[i]), 64'(32'h100 + 32'(8 * i)));
            chk("t2_data",  q_data[i], img(32'h100 + 32'(8 * i)));
            chk("t2_last",  64'(q_last[i]), 64'(i == 15));
            chk("t2_err",   64'(q_err[i]), 64'd0);
        end
        chk("t2_max_occ_ok", 64'(max_occ <= 4), 64'd1);

        // Rejected requests: misaligned, zero beats, too many beats
        repeat (3) @(posedge clock);
        #1;
        clr();
        send_req(32'h4, 5'd1, acc_a);
        wait_beats(1, 1'b0);
        chk("t3a_err",  64'(q_err[0]),  64'd1);
        chk("t3a_last", 64'(q_last[0]), 64'd1);
        chk("t3a_data", q_data[0],      64'd0);
        repeat (2) @(posedge clock);
        #1;
        send_req(32'h0, 5'd0, acc_a);
        wait_beats(2, 1'b0);
        chk("t3b_err",  64'(q_err[1]),  64'd1);
        chk("t3b_last", 64'(q_last[1]), 64'd1);
        chk("t3b_data", q_data[1],      64'd0);
        repeat (2) @(posedge clock);
        #1;
        send_req(32'h0, 5'd17, acc_a);
        wait_beats(3, 1'b0);
        chk("t3c_err",  64'(q_err[2]),  64'd1);
        chk("t3c_last", 64'(q_last[2]), 64'd1);
        repeat (3) @(posedge clock);
        chk("t3_no_reads", 64'(q_raddr.size()), 64'd0);
        chk("t3_nbeats",   64'(q_data.size()),  64'd3);

        // Address wrap
        #1;
        clr();
        send_req(32'hFFFF_FFF8, 5'd2, acc_a);
        wait_beats(2, 1'b0);
        chk("t4_raddr0", 64'(q_raddr[0]), 64'h0000_0000_FFFF_FFF8);
        chk("t4_raddr1", 64'(q_raddr[1]), 64'h0);
        chk("t4_data0",  q_data[0], 64'h5A5A_FFF8_0000_0007);
        chk("t4_data1",  q_data[1], 64'h01f2_9293_0010_029b);

        // Reset mid-transaction
        repeat (2) @(posedge clock);
        #1;
        clr();
        resp_ready = 1'b0;
        send_req(32'h200, 5'd8, acc_a);
        for (int k = 0; k < 50 && q_raddr.size() < 3; k++) @(posedge clock);
        if (q_raddr.size() < 3) fail_timeout("t5_reads");
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        chk_reset_vals("t5");
        @(posedge clock);
        #1;
        clr();
        resp_ready = 1'b1;
        send_req(32'h300, 5'd3, acc_a);
        wait_beats(3, 1'b0);
        repeat (10) @(posedge clock);
        chk("t5_nbeats", 64'(q_data.size()), 64'd3);
        chk("t5_data0",  q_data[0], 64'hA5A5_0300_FFFF_FCFF);
        chk("t5_data2",  q_data[2], img(32'h310));
        chk("t5_last2",  64'(q_last[2]), 64'd1);

        // Back-to-back requests
        #1;
        clr();
        send_req(32'h400, 5'd3, acc_a);
        send_req(32'h500, 5'd2, acc_b);
        wait_beats(5, 1'b0);
        chk("t6_b_after_a", 64'(acc_b > q_hs[2]), 64'd1);
        chk("t6_a_gapless", 64'((q_hs[1] == q_hs[0] + 1) && (q_hs[2] == q_hs[1] + 1)), 64'd1);
        for (int i = 0; i < 3; i++) chk("t6_a_data", q_data[i], img(32'h400 + 32'(8 * i)));
        for (int i = 0; i < 2; i++) chk("t6_b_data", q_data[3 + i], img(32'h500 + 32'(8 * i)));
        chk("t6_lasts", 64'({q_last[0], q_last[1], q_last[2], q_last[3], q_last[4]}), 64'b00101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/flash_reader.md
FLASH_READER -- requirements
Module: flash_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, response buffer entries; legal range 2..16.
REQ-002 Parameter MAX_BEATS, default 16, maximum beats per request.
REQ-003 clock  input  1  single clock; all logic on posedge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when valid&&ready at a posedge.
REQ-007 req_addr  input  32  byte address of first beat.
REQ-008 req_beats  input  5  number of 64-bit beats, 1..MAX_BEATS.
REQ-009 resp_valid  output  1  response beat present.
REQ-010 resp_ready  input  1  consumer accepts beat when valid&&ready.
REQ-011 resp_data  output  64  beat data, little-endian byte order as held in flash.
REQ-012 resp_last  output  1  final beat of the request.
REQ-013 resp_err  output  1  request rejected; the beat carries no data.
REQ-014 flash_r_en  output  1  read strobe to the flash model.
REQ-015 flash_r_addr  output  32  byte address to the flash model.
REQ-016 flash_r_data  input  64  flash read data, valid the cycle after flash_r_en.

Function
REQ-017 States SHALL be IDLE, ISSUE, DRAIN, ERR; req_ready SHALL be 1 only in IDLE.
REQ-018 IDLE->ERR on accept when req_addr[2:0]!=0, req_beats==0 or req_beats>MAX_BEATS; ERR SHALL present one beat: resp_err=1, resp_last=1, resp_data=0, with no flash reads; ERR->IDLE on handshake.
REQ-019 IDLE->ISSUE on any other accept; the block latches base address and beat count.
REQ-020 In ISSUE, beat i SHALL be read at flash_r_addr = base + 8*i; the add wraps mod 2^32.
REQ-021 flash_r_en SHALL assert only when FIFO occupancy + in-flight reads < FIFO_DEPTH, so the FIFO never overflows.
REQ-022 ISSUE->DRAIN in the cycle after the last beat's flash_r_en; DRAIN->IDLE on the handshake of the beat with resp_last=1.
REQ-023 flash_r_data SHALL be written to the FIFO at the posedge ending the cycle after the matching flash_r_en; only strobed reads are captured.
REQ-024 Latency: request accepted at the edge ending cycle T; first flash_r_en in T+1; first resp_valid in T+3.
REQ-025 Throughput: with resp_ready held at 1, the block SHALL sustain one beat per cycle.
REQ-026 resp_valid SHALL remain asserted, and resp_data/resp_last/resp_err SHALL remain stable, until the handshake completes.
REQ-027 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-028 resp_last SHALL be 1 on exactly beat req_beats-1; resp_err SHALL be 0 on every data beat.
REQ-029 flash_r_addr SHALL hold its last value when flash_r_en=0.

Reset
REQ-030 While reset_n=0 at a posedge, the block SHALL return to IDLE and clear the FIFO, in-flight flag and beat counters.
REQ-031 Reset values: req_ready=1 in the cycle after reset, resp_valid=0, resp_data=0, resp_last=0, resp_err=0, flash_r_en=0, flash_r_addr=0.
REQ-032 Reset mid-transaction SHALL discard all buffered and in-flight beats; no beat of that request SHALL be presented afterwards.

Structure
REQ-033 Package flash_reader_pkg SHALL hold ADDR_W=32, DATA_W=64, BEAT_W=5, the default FIFO_DEPTH and MAX_BEATS, and the state enum.
REQ-034 Sub-module flash_reader_fifo SHALL be a synchronous FIFO (data 64 + last 1) exposing occupancy count; the top holds the FSM, address counter and credit logic.
REQ-035 The bench SHALL include an assertion that no push occurs when the FIFO is full.

Verification
REQ-036 Addr 0x0, beats 2, resp_ready=1 over default flash image -> data 0x01f292930010029b then last beat with resp_last=1; first resp_valid exactly 3 cycles after accept.
REQ-037 Addr 0x100, beats 16, resp_ready toggled 1/0 every cycle -> 16 beats in address order, flash_r_addr 0x100..0x178, no overflow, occupancy never exceeds 4.
REQ-038 Addr 0x4, beats 1 -> single beat resp_err=1, resp_last=1, data 0, flash_r_en never asserted; beats 0 at addr 0x0 -> same.
REQ-039 Addr 0xFFFFFFF8, beats 2 -> flash_r_addr 0xFFFFFFF8 then 0x00000000.
REQ-040 Beats 8, resp_ready=0, reset_n pulsed low for one cycle after 3 reads -> all outputs at reset values; next request returns only its own beats.
REQ-041 Back-to-back: second request held valid during the first -> req_ready low until the last beat of the first is accepted; no gap or interleaving of beats.
